biquad_tdm_cascade: RTL and testbench

//  Time-multiplexed cascade of NSEC biquad sections serving NCH independent channels with one shared MAC.

---
 rtl/biquad_tdm_cascade.sv | 253 +++++++++++++++++++++++++
 tb/tb_biquad_tdm_cascade.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/biquad_tdm_cascade.sv
// Time-multiplexed biquad cascade: NSEC sections x NCH channels sharing one MAC.
// Coefficients are written over a Wishbone slave into a shadow bank and copied
// to the active bank atomically, only while no sample is in flight.
module biquad_tdm_cascade #(
  parameter int unsigned DATAWIDTH = 16,
  parameter int unsigned COEFWIDTH = 16,
  parameter int unsigned NCH       = 4,
  parameter int unsigned NSEC      = 2,
  localparam int unsigned CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        we_i,
  input  logic                        stb_i,
  output logic                        ack_o,
  input  logic [7:0]                  adr_i,
  input  logic [15:0]                 dat_i,
  output logic [15:0]                 dat_o,
  input  logic signed [DATAWIDTH-1:0] x_i,
  input  logic [CHW-1:0]              ch_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  output logic signed [DATAWIDTH-1:0] y_o,
  output logic [CHW-1:0]              ych_o,
  output logic                        yvalid_o
);

  localparam int unsigned SECW = (NSEC > 1) ? $clog2(NSEC) : 1;
  localparam int unsigned NDL  = NCH * NSEC;
  localparam int unsigned IDXW = (NDL > 1) ? $clog2(NDL) : 1;
  localparam int unsigned PW   = DATAWIDTH + COEFWIDTH;
  localparam int unsigned AW   = PW + 3;

  localparam logic signed [AW-1:0] RndBias = AW'(2 ** (COEFWIDTH - 2));
  localparam logic signed [AW-1:0] SatHi   = AW'(2 ** (DATAWIDTH - 1) - 1);
  localparam logic signed [AW-1:0] SatLo   = ~SatHi;

  typedef enum logic [1:0] {StIdle, StMac, StUpd, StOut} state_e;

  // Bus and coefficient storage, indexed [section][coef address 0..4]
  logic        ack_q;
  logic [15:0] dat_q;
  logic [15:0] shadow_q [NSEC][5];
  logic [15:0] act_q    [NSEC][5];
  logic        clr_pend_q, commit_pend_q, sat_q;

  // Sequencer and datapath state
  state_e                       state_q;
  logic [SECW-1:0]              sec_q;
  logic [2:0]                   tap_q;
  logic [CHW-1:0]               ch_q;
  logic signed [DATAWIDTH-1:0]  xin_q;
  logic signed [AW-1:0]         acc_q;
  logic signed [DATAWIDTH-1:0]  y_q;
  logic [CHW-1:0]               ych_q;
  logic                         yvalid_q;
  logic signed [DATAWIDTH-1:0]  x1_q [NDL];
  logic signed [DATAWIDTH-1:0]  x2_q [NDL];
  logic signed [DATAWIDTH-1:0]  y1_q [NDL];
  logic signed [DATAWIDTH-1:0]  y2_q [NDL];

  // Bus decode
  logic            access, wr_ctrl, is_ctrl, map_hit, busy;
  logic [SECW-1:0] bus_sec;
  logic [2:0]      bus_coef;
  logic [15:0]     rdata;

  assign access   = stb_i & ~ack_q;
  assign is_ctrl  = (adr_i == 8'hFF);
  assign bus_sec  = adr_i[3 +: SECW];
  assign bus_coef = adr_i[2:0];
  assign map_hit  = ({1'b0, adr_i[7:3]} < 6'(NSEC)) && (bus_coef < 3'd5) && !is_ctrl;
  assign wr_ctrl  = access & we_i & is_ctrl;
  assign busy     = (state_q != StIdle);

  // Read mux: CTRL status or zero-extended shadow coefficient
  always_comb begin
    rdata = '0;
    if (is_ctrl) begin
      rdata = {12'b0, sat_q, commit_pend_q, clr_pend_q, busy};
    end else if (map_hit) begin
      rdata = shadow_q[bus_sec][bus_coef];
    end
  end

  // Pending CLR/COMMIT fire in IDLE, or on the OUT edge that re-enters IDLE
  logic apply, clr_req, commit_req, do_clr, do_commit, clamp, sat_hit;
  assign apply      = (state_q == StIdle) || (state_q == StOut);
  assign clr_req    = clr_pend_q | (wr_ctrl & dat_i[0]);
  assign commit_req = commit_pend_q | (wr_ctrl & dat_i[1]);
  assign do_clr     = clr_req & apply;
  assign do_commit  = commit_req & apply;
  assign sat_hit    = (state_q == StUpd) & clamp;

  // MAC operand select and rounding/saturation of the accumulator
  logic [IDXW-1:0]             idx;
  logic                        ch_ok;
  logic [2:0]                  coef_sel;
  logic [15:0]                 coef_raw;
  logic signed [COEFWIDTH-1:0] coef;
  logic signed [DATAWIDTH-1:0] opnd;
  logic signed [PW-1:0]        coef_ext, opnd_ext, prod;
  logic signed [AW-1:0]        acc_d, rnd_sum, rnd_shr;
  logic signed [DATAWIDTH-1:0] r;

  always_comb begin
    ch_ok    = ({1'b0, ch_q} < (CHW + 1)'(NCH));
    idx      = IDXW'(ch_q) * IDXW'(NSEC) + IDXW'(sec_q);
    // Tap order b10, b11, b12, a11, a12 maps onto coef addresses 2, 3, 4, 0, 1
    coef_sel = (tap_q < 3'd3) ? tap_q + 3'd2 : tap_q - 3'd3;
    coef_raw = act_q[sec_q][coef_sel];
    coef     = coef_raw[15 -: COEFWIDTH];
    opnd     = '0;
    unique case (tap_q)
      3'd0: opnd = xin_q;
      3'd1: opnd = ch_ok ? x1_q[idx] : '0;
      3'd2: opnd = ch_ok ? x2_q[idx] : '0;
      3'd3: opnd = ch_ok ? y1_q[idx] : '0;
      3'd4: opnd = ch_ok ? y2_q[idx] : '0;
      default: opnd = '0;
    endcase
    coef_ext = {{DATAWIDTH{coef[COEFWIDTH-1]}}, coef};
    opnd_ext = {{COEFWIDTH{opnd[DATAWIDTH-1]}}, opnd};
    prod     = coef_ext * opnd_ext;
    acc_d    = ((tap_q == 3'd0) ? '0 : acc_q) + {{3{prod[PW-1]}}, prod};

    rnd_sum  = acc_q + RndBias;
    rnd_shr  = rnd_sum >>> (COEFWIDTH - 1);
    clamp    = 1'b0;
    r        = rnd_shr[DATAWIDTH-1:0];
    if (rnd_shr > SatHi) begin
      r     = SatHi[DATAWIDTH-1:0];
      clamp = 1'b1;
    end else if (rnd_shr < SatLo) begin
      r     = SatLo[DATAWIDTH-1:0];
      clamp = 1'b1;
    end
  end

  // Wishbone slave: single-cycle registered ack, shadow bank writes
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
      for (int s = 0; s < NSEC; s++) begin
        for (int c = 0; c < 5; c++) shadow_q[s][c] <= '0;
      end
    end else begin
      ack_q <= access;
      dat_q <= access ? rdata : '0;
      if (access && we_i && map_hit) shadow_q[bus_sec][bus_coef] <= dat_i;
    end
  end

  // Control: pending flags, atomic commit, sticky saturation flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clr_pend_q    <= 1'b0;
      commit_pend_q <= 1'b0;
      sat_q         <= 1'b0;
      for (int s = 0; s < NSEC; s++) begin
        for (int c = 0; c < 5; c++) act_q[s][c] <= '0;
      end
    end else begin
      if (do_commit) begin
        for (int s = 0; s < NSEC; s++) begin
          for (int c = 0; c < 5; c++) act_q[s][c] <= shadow_q[s][c];
        end
      end
      clr_pend_q    <= clr_req & ~apply;
      commit_pend_q <= commit_req & ~apply;
      // A new clamp wins over a simultaneous SATCLR
      if (sat_hit) sat_q <= 1'b1;
      else if (wr_ctrl && dat_i[2]) sat_q <= 1'b0;
    end
  end

  // Sequencer: accept, 5 MAC taps + 1 update per section, then one OUT cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      sec_q    <= '0;
      tap_q    <= '0;
      ch_q     <= '0;
      xin_q    <= '0;
      acc_q    <= '0;
      y_q      <= '0;
      ych_q    <= '0;
      yvalid_q <= 1'b0;
      for (int i = 0; i < NDL; i++) begin
        x1_q[i] <= '0;
        x2_q[i] <= '0;
        y1_q[i] <= '0;
        y2_q[i] <= '0;
      end
    end else begin
      yvalid_q <= 1'b0;
      if (do_clr) begin
        for (int i = 0; i < NDL; i++) begin
          x1_q[i] <= '0;
          x2_q[i] <= '0;
          y1_q[i] <= '0;
          y2_q[i] <= '0;
        end
      end
      unique case (state_q)
        StIdle: begin
          if (valid_i) begin
            state_q <= StMac;
            ch_q    <= ch_i;
            xin_q   <= x_i;
            sec_q   <= '0;
            tap_q   <= '0;
          end
        end
        StMac: begin
          acc_q <= acc_d;
          if (tap_q == 3'd4) state_q <= StUpd;
          else tap_q <= tap_q + 3'd1;
        end
        StUpd: begin
          if (ch_ok) begin
            x1_q[idx] <= xin_q;
            x2_q[idx] <= x1_q[idx];
            y1_q[idx] <= r;
            y2_q[idx] <= y1_q[idx];
          end
          xin_q <= r;
          tap_q <= '0;
          if (sec_q == SECW'(NSEC - 1)) begin
            state_q  <= StOut;
            y_q      <= r;
            ych_q    <= ch_q;
            yvalid_q <= ch_ok;
          end else begin
            sec_q   <= sec_q + SECW'(1);
            state_q <= StMac;
          end
        end
        StOut: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ack_o    = ack_q;
  assign dat_o    = dat_q;
  assign ready_o  = (state_q == StIdle) & ~rst_i;
  assign y_o      = y_q;
  assign ych_o    = ych_q;
  assign yvalid_o = yvalid_q;

endmodule

// File: tb/tb_biquad_tdm_cascade.sv
// Directed bench for biquad_tdm_cascade (NSEC=2, NCH=4) with hand-computed results.
module tb_biquad_tdm_cascade;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0, stb = 1'b0, ack;
  logic [7:0]  adr = '0;
  logic [15:0] dat_w = '0, dat_r;
  logic [15:0] x = '0;
  logic [1:0]  ch = '0;
  logic        valid = 1'b0, ready;
  logic [15:0] y;
  logic [1:0]  ych;
  logic        yvalid;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int          cyc = 0;

  logic [15:0] yq[$];
  logic [1:0]  chq[$];
  int          cycq[$];

  biquad_tdm_cascade #(
    .DATAWIDTH(16),
    .COEFWIDTH(16),
    .NCH(4),
    .NSEC(2)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (we),
    .stb_i   (stb),
    .ack_o   (ack),
    .adr_i   (adr),
    .dat_i   (dat_w),
    .dat_o   (dat_r),
    .x_i     (x),
    .ch_i    (ch),
    .valid_i (valid),
    .ready_o (ready),
    .y_o     (y),
    .ych_o   (ych),
    .yvalid_o(yvalid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: every cycle with yvalid high is recorded
  always @(negedge clk) begin
    if (yvalid) begin
      yq.push_back(y);
      chq.push_back(ych);
      cycq.push_back(cyc);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_xfer(input logic w, input logic [7:0] a, input logic [15:0] d,
                          output logic [15:0] q);
    int n;
    @(negedge clk);
    stb = 1'b1; we = w; adr = a; dat_w = d;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!ack && n < 8);
    q = dat_r;
    @(negedge clk);
    stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    logic [15:0] q;
    bus_xfer(1'b1, a, d, q);
  endtask

  task automatic rd_check(input string tag, input logic [7:0] a, input logic [15:0] exp);
    logic [15:0] q;
    bus_xfer(1'b0, a, 16'h0, q);
    check(tag, q, exp);
  endtask

  // Write all five coefficients of one section into the shadow bank
  task automatic cfg(input logic [4:0] s, input logic [15:0] a11, input logic [15:0] a12,
                     input logic [15:0] b10, input logic [15:0] b11, input logic [15:0] b12);
    wr({s, 3'd0}, a11);
    wr({s, 3'd1}, a12);
    wr({s, 3'd2}, b10);
    wr({s, 3'd3}, b11);
    wr({s, 3'd4}, b12);
  endtask

  task automatic send(input logic [1:0] c, input logic [15:0] v, output int acc_cyc);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready && n < 100) begin
      @(negedge clk); n++;
    end
    check("ready_before_send", ready, 1);
    valid = 1'b1; ch = c; x = v;
    @(posedge clk); #1;
    acc_cyc = cyc;
    valid = 1'b0;
  endtask

  task automatic get_y(input string tag, input logic [15:0] ey, input logic [1:0] ec,
                       output int y_cyc);
    int n;
    logic [15:0] gy;
    logic [1:0]  gc;
    n = 0;
    gy = 'x; gc = 'x; y_cyc = -1000;
    while (yq.size() == 0 && n < 200) begin
      @(negedge clk); n++;
    end
    if (yq.size() != 0) begin
      gy = yq.pop_front();
      gc = chq.pop_front();
      y_cyc = cycq.pop_front();
    end
    check({tag, ".y"}, gy, ey);
    check({tag, ".ch"}, gc, ec);
  endtask

  task automatic run(input string tag, input logic [1:0] c, input logic [15:0] v,
                     input logic [15:0] ey);
    int a, b;
    send(c, v, a);
    get_y(tag, ey, c, b);
  endtask

  initial begin
    int a_cyc, y_cyc, qn;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst.ready", ready, 0);
    check("rst.ack", ack, 0);
    check("rst.yvalid", yvalid, 0);
    check("rst.y", y, 0);
    check("rst.dat", dat_r, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst.ready_after", ready, 1);
    rd_check("rst.ctrl", 8'hFF, 16'h0000);

    // Coefficient access and unmapped addresses
    wr(8'h0B, 16'h1234);
    rd_check("coef.rdback", 8'h0B, 16'h1234);
    wr(8'h12, 16'hBEEF);
    rd_check("coef.sec2", 8'h12, 16'h0000);
    rd_check("coef.sec0_alias", 8'h02, 16'h0000);
    wr(8'h05, 16'h5555);
    rd_check("coef.c5", 8'h05, 16'h0000);
    rd_check("coef.c6", 8'h06, 16'h0000);

    // Gain 0.5 per section: overall 0.25, rounding half up
    cfg(5'd0, 16'h0, 16'h0, 16'h4000, 16'h0, 16'h0);
    cfg(5'd1, 16'h0, 16'h0, 16'h4000, 16'h0, 16'h0);
    wr(8'hFF, 16'h0003);
    rd_check("gain.ctrl", 8'hFF, 16'h0000);
    send(2'd0, 16'h4000, a_cyc);
    get_y("gain.pos", 16'h1000, 2'd0, y_cyc);
    check("gain.latency", y_cyc - a_cyc + 1, 13);
    run("gain.neg", 2'd0, 16'hC000, 16'hF000);
    run("gain.one", 2'd0, 16'h0001, 16'h0001);
    run("gain.minus1", 2'd0, 16'hFFFF, 16'h0000);

    // Impulse through recursive section 0, halved by section 1
    cfg(5'd0, 16'h4000, 16'h0, 16'h7FFF, 16'h0, 16'h0);
    wr(8'hFF, 16'h0003);
    run("imp.0", 2'd0, 16'h7FFF, 16'h3FFF);
    run("imp.1", 2'd0, 16'h0000, 16'h2000);
    run("imp.2", 2'd0, 16'h0000, 16'h1000);

    // Channel independence: ch2 impulse interleaved with ch0 zeros
    wr(8'hFF, 16'h0001);
    run("chan.c2_0", 2'd2, 16'h7FFF, 16'h3FFF);
    run("chan.c0_0", 2'd0, 16'h0000, 16'h0000);
    run("chan.c2_1", 2'd2, 16'h0000, 16'h2000);
    run("chan.c0_1", 2'd0, 16'h0000, 16'h0000);
    run("chan.c2_2", 2'd2, 16'h0000, 16'h1000);

    // Saturation and sticky flag
    cfg(5'd0, 16'h0, 16'h0, 16'h7FFF, 16'h7FFF, 16'h0);
    cfg(5'd1, 16'h0, 16'h0, 16'h7FFF, 16'h7FFF, 16'h0);
    wr(8'hFF, 16'h0003);
    run("sat.0", 2'd1, 16'h7FFF, 16'h7FFD);
    rd_check("sat.flag0", 8'hFF, 16'h0000);
    run("sat.1", 2'd1, 16'h7FFF, 16'h7FFF);
    rd_check("sat.flag1", 8'hFF, 16'h0008);
    wr(8'hFF, 16'h0004);
    rd_check("sat.clr", 8'hFF, 16'h0000);

    // COMMIT while busy: current sample keeps old coefs
    cfg(5'd0, 16'h0, 16'h0, 16'h4000, 16'h0, 16'h0);
    cfg(5'd1, 16'h0, 16'h0, 16'h4000, 16'h0, 16'h0);
    wr(8'hFF, 16'h0003);
    wr(8'h02, 16'h7FFF);
    send(2'd3, 16'h4000, a_cyc);
    wr(8'hFF, 16'h0002);
    rd_check("commit.pend", 8'hFF, 16'h0005);
    get_y("commit.old", 16'h1000, 2'd3, y_cyc);
    rd_check("commit.done", 8'hFF, 16'h0000);
    run("commit.new", 2'd3, 16'h4000, 16'h2000);

    // Reset mid-sample: sample dropped, ready right after release
    send(2'd0, 16'h4000, a_cyc);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst.ready", ready, 0);
    check("midrst.yvalid", yvalid, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst.ready_after", ready, 1);
    repeat (20) @(negedge clk);
    qn = yq.size();
    check("midrst.no_y", qn, 0);
    rd_check("midrst.shadow", 8'h02, 16'h0000);
    rd_check("midrst.ctrl", 8'hFF, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
